// File: rtl/mips_pkg.sv
// Shared encodings and types for the MIPS pipeline: load width/sign codes
// and the MEM/WB pipeline register layout.
package mips_pkg;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;

  // Codes 3'b101..3'b111 are not listed and behave as LS_W.
  typedef enum logic [2:0] {
    LS_W  = 3'b000,
    LS_B  = 3'b001,
    LS_BU = 3'b010,
    LS_H  = 3'b011,
    LS_HU = 3'b100
  } ld_size_e;

  typedef struct packed {
    logic              valid;
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] data;
    logic [DATA_W-1:0] alu;
    logic              regwrite;
    logic              memtoreg;
    logic [2:0]        ldsize;
  } mem_wb_t;

  function automatic logic [DATA_W-1:0] sext8(input logic [7:0] b, input logic sgn);
    return {{24{sgn & b[7]}}, b};
  endfunction

  function automatic logic [DATA_W-1:0] sext16(input logic [15:0] h, input logic sgn);
    return {{16{sgn & h[15]}}, h};
  endfunction

endpackage

// File: rtl/mem_wb_cycle_load_align.sv
// Big-endian byte/halfword extraction with sign/zero extension and
// misalignment detection for the writeback stage.
module load_align
  import mips_pkg::*;
(
  input  logic [DATA_W-1:0] word_i,
  input  logic [1:0]        addr_i,
  input  logic [2:0]        ld_size_i,
  output logic [DATA_W-1:0] data_o,
  output logic              misaligned_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Byte 0 lives in the most significant lane.
  always_comb begin
    byte_sel = word_i[31:24];
    case (addr_i)
      2'd0: byte_sel = word_i[31:24];
      2'd1: byte_sel = word_i[23:16];
      2'd2: byte_sel = word_i[15:8];
      2'd3: byte_sel = word_i[7:0];
      default: byte_sel = word_i[31:24];
    endcase
  end

  assign half_sel = addr_i[1] ? word_i[15:0] : word_i[31:16];

  always_comb begin
    data_o       = word_i;
    misaligned_o = 1'b0;
    case (ld_size_i)
      LS_B: begin
        data_o = sext8(byte_sel, 1'b1);
      end
      LS_BU: begin
        data_o = sext8(byte_sel, 1'b0);
      end
      LS_H: begin
        data_o       = sext16(half_sel, 1'b1);
        misaligned_o = addr_i[0];
      end
      LS_HU: begin
        data_o       = sext16(half_sel, 1'b0);
        misaligned_o = addr_i[0];
      end
      default: begin
        data_o       = word_i;
        misaligned_o = |addr_i;
      end
    endcase
  end

endmodule

// File: rtl/mem_wb_cycle.sv
// MEM/WB pipeline register plus writeback: load alignment, result mux,
// register-file write port, retired-instruction counter and misalign flag.
module mem_wb_cycle
  import mips_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_in,
  input  logic [DATA_W-1:0] ReadData,
  input  logic [DATA_W-1:0] ALUres_out,
  input  logic [REG_W-1:0]  des_reg_out,
  input  logic              RegWrite,
  input  logic              MemtoReg,
  input  logic [2:0]        ld_size,
  input  logic              stall,
  input  logic              flush,
  output logic              wb_en,
  output logic [REG_W-1:0]  wb_reg,
  output logic [DATA_W-1:0] wb_data,
  output logic [DATA_W-1:0] retired,
  output logic              misalign,
  output logic [DATA_W-1:0] misalign_addr
);

  mem_wb_t           stage_q, stage_d;
  logic [DATA_W-1:0] retired_q, retired_d;
  logic              misalign_q, misalign_d;
  logic [DATA_W-1:0] misalign_addr_q, misalign_addr_d;

  logic [DATA_W-1:0] load_data;
  logic              load_misaligned;
  logic              bad;
  logic              leaving;

  load_align u_load_align (
    .word_i       (stage_q.data),
    .addr_i       (stage_q.alu[1:0]),
    .ld_size_i    (stage_q.ldsize),
    .data_o       (load_data),
    .misaligned_o (load_misaligned)
  );

  assign bad = stage_q.valid & stage_q.memtoreg & load_misaligned;

  // The held instruction departs whenever the stage is not frozen; a flush
  // also pushes it out, even if stall is raised at the same time.
  assign leaving = stage_q.valid & (flush | ~stall);

  always_comb begin
    stage_d = stage_q;
    if (flush) begin
      stage_d.valid = 1'b0;
    end else if (!stall) begin
      stage_d.valid    = valid_in;
      stage_d.rd       = des_reg_out;
      stage_d.data     = ReadData;
      stage_d.alu      = ALUres_out;
      stage_d.regwrite = RegWrite;
      stage_d.memtoreg = MemtoReg;
      stage_d.ldsize   = ld_size;
    end
  end

  always_comb begin
    retired_d       = retired_q + {{(DATA_W-1){1'b0}}, leaving};
    misalign_d      = misalign_q;
    misalign_addr_d = misalign_addr_q;
    if (bad && !misalign_q) begin
      misalign_d      = 1'b1;
      misalign_addr_d = stage_q.alu;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q         <= '0;
      retired_q       <= '0;
      misalign_q      <= 1'b0;
      misalign_addr_q <= '0;
    end else begin
      stage_q         <= stage_d;
      retired_q       <= retired_d;
      misalign_q      <= misalign_d;
      misalign_addr_q <= misalign_addr_d;
    end
  end

  assign wb_reg        = stage_q.rd;
  assign wb_data       = stage_q.memtoreg ? load_data : stage_q.alu;
  assign wb_en         = stage_q.valid & stage_q.regwrite & (|stage_q.rd) & ~bad;
  assign retired       = retired_q;
  assign misalign      = misalign_q;
  assign misalign_addr = misalign_addr_q;

endmodule

// File: tb/tb_mem_wb_cycle.sv
// Self-checking bench for mem_wb_cycle: directed scenarios followed by random
// traffic, all compared against a behavioural writeback model.
module tb_mem_wb_cycle;
  import mips_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        valid_in;
  logic [31:0] ReadData;
  logic [31:0] ALUres_out;
  logic [4:0]  des_reg_out;
  logic        RegWrite;
  logic        MemtoReg;
  logic [2:0]  ld_size;
  logic        stall;
  logic        flush;
  logic        wb_en;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic [31:0] retired;
  logic        misalign;
  logic [31:0] misalign_addr;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state: the one instruction sitting in writeback.
  logic        m_valid;
  logic [4:0]  m_rd;
  logic [31:0] m_data, m_alu;
  logic        m_rw, m_mtr;
  logic [2:0]  m_sz;
  logic [31:0] m_ret;
  logic        m_mis;
  logic [31:0] m_maddr;

  mem_wb_cycle dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .valid_in      (valid_in),
    .ReadData      (ReadData),
    .ALUres_out    (ALUres_out),
    .des_reg_out   (des_reg_out),
    .RegWrite      (RegWrite),
    .MemtoReg      (MemtoReg),
    .ld_size       (ld_size),
    .stall         (stall),
    .flush         (flush),
    .wb_en         (wb_en),
    .wb_reg        (wb_reg),
    .wb_data       (wb_data),
    .retired       (retired),
    .misalign      (misalign),
    .misalign_addr (misalign_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Returns {misaligned, loaded value}; byte offset 0 is the leftmost byte.
  function automatic logic [32:0] ref_load(input logic [31:0] w, input logic [31:0] a,
                                           input logic [2:0] sz);
    int off;
    int v;
    logic [7:0]  by;
    logic [15:0] hw;
    off = int'(a % 4);
    by  = 8'((w >> (8 * (3 - off))) & 32'hFF);
    hw  = 16'((w >> (16 * (1 - off / 2))) & 32'hFFFF);
    case (sz)
      3'd1: begin v = int'(by); if (v >= 128) v = v - 256; return {1'b0, 32'(v)}; end
      3'd2: return {1'b0, 32'(by)};
      3'd3: begin v = int'(hw); if (v >= 32768) v = v - 65536; return {(off % 2) != 0, 32'(v)}; end
      3'd4: return {(off % 2) != 0, 32'(hw)};
      default: return {off != 0, w};
    endcase
  endfunction

  function automatic logic m_bad();
    logic [32:0] r;
    r = ref_load(m_data, m_alu, m_sz);
    return m_valid && m_mtr && r[32];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [32:0] r;
    logic [31:0] e_data;
    logic        e_en;
    r      = ref_load(m_data, m_alu, m_sz);
    e_data = m_mtr ? r[31:0] : m_alu;
    e_en   = m_valid && m_rw && (m_rd != 5'd0) && !m_bad();
    check({tag, ".wb_en"},   {31'd0, wb_en}, {31'd0, e_en});
    check({tag, ".wb_reg"},  {27'd0, wb_reg}, {27'd0, m_rd});
    check({tag, ".wb_data"}, wb_data, e_data);
    check({tag, ".retired"}, retired, m_ret);
    check({tag, ".misalign"}, {31'd0, misalign}, {31'd0, m_mis});
    check({tag, ".maddr"},   misalign_addr, m_maddr);
  endtask

  task automatic model_reset();
    m_valid = 0; m_rd = 0; m_data = 0; m_alu = 0; m_rw = 0; m_mtr = 0; m_sz = 0;
    m_ret = 0; m_mis = 0; m_maddr = 0;
  endtask

  // Drive one cycle of inputs, advance one edge, update model, compare.
  task automatic step(input string tag, input logic v, input logic [31:0] rdata,
                      input logic [31:0] alu, input logic [4:0] rd, input logic rw,
                      input logic mtr, input logic [2:0] sz, input logic st, input logic fl);
    valid_in = v; ReadData = rdata; ALUres_out = alu; des_reg_out = rd;
    RegWrite = rw; MemtoReg = mtr; ld_size = sz; stall = st; flush = fl;
    @(posedge clk);
    if (m_valid && (fl || !st)) m_ret = m_ret + 32'd1;
    if (m_bad() && !m_mis) begin m_mis = 1; m_maddr = m_alu; end
    if (fl) m_valid = 0;
    else if (!st) begin
      m_valid = v; m_rd = rd; m_data = rdata; m_alu = alu; m_rw = rw; m_mtr = mtr; m_sz = sz;
    end
    #1;
    check_all(tag);
  endtask

  task automatic bubble(input string tag);
    step(tag, 0, 32'h0, 32'h0, 5'd0, 0, 0, 3'd0, 0, 0);
  endtask

  initial begin
    rst_n = 0; valid_in = 0; ReadData = 0; ALUres_out = 0; des_reg_out = 0;
    RegWrite = 0; MemtoReg = 0; ld_size = 0; stall = 0; flush = 0;
    model_reset();
    #12;
    check_all("reset");
    rst_n = 1;
    @(negedge clk);

    // ALU writeback, retire counted on the following edge
    step("alu", 1, 32'hDEAD_BEEF, 32'h0000_1234, 5'd8, 1, 0, LS_W, 0, 0);
    check("alu.tp_data", wb_data, 32'h0000_1234);
    bubble("alu_leave");
    check("alu.tp_ret", retired, 32'd1);

    // Byte loads
    step("lb0", 1, 32'h80FF_7F01, 32'h100, 5'd3, 1, 1, LS_B, 0, 0);
    check("lb0.tp", wb_data, 32'hFFFF_FF80);
    step("lbu2", 1, 32'h80FF_7F01, 32'h102, 5'd4, 1, 1, LS_BU, 0, 0);
    check("lbu2.tp", wb_data, 32'h0000_007F);
    step("lb3", 1, 32'h80FF_7F01, 32'h103, 5'd5, 1, 1, LS_B, 0, 0);
    check("lb3.tp", wb_data, 32'h0000_0001);

    // Halfword loads
    step("lh2", 1, 32'h1234_8765, 32'h202, 5'd6, 1, 1, LS_H, 0, 0);
    check("lh2.tp", wb_data, 32'hFFFF_8765);
    step("lhu0", 1, 32'h1234_8765, 32'h200, 5'd7, 1, 1, LS_HU, 0, 0);
    check("lhu0.tp", wb_data, 32'h0000_1234);

    // Misaligned loads: first address sticks
    step("lw_mis", 1, 32'h1111_2222, 32'h301, 5'd9, 1, 1, LS_W, 0, 0);
    check("lw_mis.tp_en", {31'd0, wb_en}, 32'd0);
    step("lh_mis", 1, 32'h3333_4444, 32'h401, 5'd10, 1, 1, LS_H, 0, 0);
    check("lw_mis.tp_flag", {31'd0, misalign}, 32'd1);
    bubble("mis_leave");
    check("lh_mis.tp_addr", misalign_addr, 32'h301);

    // Stall for three cycles, then stall+flush together
    step("st_load", 1, 32'h0, 32'hCAFE_0001, 5'd11, 1, 0, LS_W, 0, 0);
    for (int i = 0; i < 3; i++)
      step("stall", 1, 32'h5555_5555, 32'h9999_0000 + 32'(i), 5'd12, 1, 0, LS_W, 1, 0);
    check("stall.tp_data", wb_data, 32'hCAFE_0001);
    step("st_fl", 1, 32'h0, 32'h7777, 5'd13, 1, 0, LS_W, 1, 1);
    check("st_fl.tp_en", {31'd0, wb_en}, 32'd0);

    // Write to $0 is suppressed
    step("r0", 1, 32'h0, 32'hABCD, 5'd0, 1, 0, LS_W, 0, 0);
    check("r0.tp_en", {31'd0, wb_en}, 32'd0);

    // Counter wrap from a forced preload
    step("wrap_load", 1, 32'h0, 32'h42, 5'd14, 1, 0, LS_W, 0, 0);
    force dut.retired_q = 32'hFFFF_FFFF;
    #1;
    release dut.retired_q;
    m_ret = 32'hFFFF_FFFF;
    step("wrap", 0, 32'h0, 32'h0, 5'd0, 0, 0, LS_W, 0, 0);
    check("wrap.tp", retired, 32'd0);

    // Reset in the middle of a stall clears every output at once
    step("rst_load", 1, 32'h0, 32'h0BAD_F00D, 5'd15, 1, 0, LS_W, 0, 0);
    step("rst_stall", 1, 32'h0, 32'h1, 5'd16, 1, 0, LS_W, 1, 0);
    #2;
    rst_n = 0;
    #1;
    model_reset();
    check_all("async_rst");
    check("async_rst.tp_data", wb_data, 32'h0);
    #1;
    rst_n = 1;
    stall = 0;

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      logic [31:0] ra;
      ra = $urandom;
      step("rand", 1'($urandom_range(0, 3) != 0), $urandom, ra, 5'($urandom_range(0, 31)),
           1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
           3'($urandom_range(0, 7)), 1'($urandom_range(0, 4) == 0),
           1'($urandom_range(0, 9) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
